// File: rtl/ioctl_sdram_arbiter.sv
// Front end for the single-port 8-bit sdram controller: FIFO-buffered data_io
// download writes take absolute priority over round-robin core request ports.
module ioctl_sdram_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DL_BASE    = 0,
    parameter int unsigned DL_LIMIT   = 65535
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       ioctl_download,
    input  logic                       ioctl_wr,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    input  logic [CHANNELS-1:0]        req,
    input  logic [CHANNELS-1:0]        we,
    input  logic [CHANNELS*ADDR_W-1:0] addr,
    input  logic [CHANNELS*8-1:0]      wdata,
    output logic [CHANNELS-1:0]        ack,
    output logic [7:0]                 rdata,
    output logic [ADDR_W-1:0]          sdram_addr,
    output logic [7:0]                 sdram_din,
    output logic                       sdram_rd,
    output logic                       sdram_we,
    input  logic [7:0]                 sdram_dout,
    input  logic                       sdram_ready,
    output logic                       dl_busy,
    output logic                       dl_done,
    output logic                       dl_overflow,
    output logic                       dl_range_err
);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SW  = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [ADDR_W+7:0] r_mem [FIFO_DEPTH];
    logic [FAW-1:0]    r_wptr, r_rptr;
    logic [FAW:0]      r_count, w_count_next;
    logic              w_empty, w_full, w_push, w_pop, w_range_bad, w_fifo_drop;
    logic [SW-1:0]     w_sum;

    logic              r_fgrant, r_we;
    logic [CW-1:0]     r_sel, r_rr, w_core_sel, w_cand;
    logic              w_core_hit;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din, r_rdata;
    logic [ADDR_W-1:0] w_ch_addr  [CHANNELS];
    logic [7:0]        w_ch_wdata [CHANNELS];

    logic r_dl_q, r_dl_seen, r_dl_done, r_overflow, r_range_err;
    logic w_dl_rise, w_dl_end;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_ch_addr[g]  = addr[g*ADDR_W +: ADDR_W];
        assign w_ch_wdata[g] = wdata[g*8 +: 8];
    end

    assign w_sum        = SW'(ioctl_addr[ADDR_W-1:0]) + SW'(DL_BASE);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == (FAW+1)'(FIFO_DEPTH));
    assign w_pop        = (r_state == S_DONE) && r_fgrant;
    assign w_range_bad  = ioctl_wr && (w_sum > SW'(DL_LIMIT));
    assign w_fifo_drop  = ioctl_wr && !w_range_bad && w_full && !w_pop;
    assign w_push       = ioctl_wr && !w_range_bad && (!w_full || w_pop);
    assign w_count_next = r_count + (FAW+1)'(w_push) - (FAW+1)'(w_pop);
    assign w_dl_rise    = ioctl_download && !r_dl_q;
    // Looking at the post-edge FIFO count lets the pulse land right after the last pop.
    assign w_dl_end     = r_dl_seen && !ioctl_download && (w_count_next == '0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_sum[ADDR_W-1:0], ioctl_dout};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_core_hit = 1'b0;
        w_core_sel = '0;
        w_cand     = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_cand = CW'((32'(r_rr) + k) % CHANNELS);
            if (!w_core_hit && req[w_cand]) begin
                w_core_hit = 1'b1;
                w_core_sel = w_cand;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty || w_core_hit) w_state_next = S_ISSUE;
            S_ISSUE: if (sdram_ready) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sdram_rd = (r_state == S_ISSUE) && !r_we;
        sdram_we = (r_state == S_ISSUE) && r_we;
        ack      = '0;
        if ((r_state == S_DONE) && !r_fgrant) ack[r_sel] = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_fgrant <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_rr     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_fgrant        <= 1'b1;
                        r_we            <= 1'b1;
                        {r_addr, r_din} <= r_mem[r_rptr];
                    end else if (w_core_hit) begin
                        r_fgrant <= 1'b0;
                        r_sel    <= w_core_sel;
                        r_we     <= we[w_core_sel];
                        r_addr   <= w_ch_addr[w_core_sel];
                        r_din    <= w_ch_wdata[w_core_sel];
                    end
                end
                S_ISSUE: if (sdram_ready && !r_we) r_rdata <= sdram_dout;
                S_DONE:  if (!r_fgrant) r_rr <= (r_sel == CW'(CHANNELS-1)) ? '0 : r_sel + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_q      <= 1'b0;
            r_dl_seen   <= 1'b0;
            r_dl_done   <= 1'b0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_dl_q    <= ioctl_download;
            r_dl_done <= w_dl_end;
            if (ioctl_download)  r_dl_seen <= 1'b1;
            else if (w_dl_end)   r_dl_seen <= 1'b0;
            if (w_range_bad)     r_range_err <= 1'b1;
            else if (w_dl_rise)  r_range_err <= 1'b0;
            if (w_fifo_drop)     r_overflow <= 1'b1;
            else if (w_dl_rise)  r_overflow <= 1'b0;
        end
    end

    assign rdata        = r_rdata;
    assign sdram_addr   = r_addr;
    assign sdram_din    = r_din;
    assign dl_busy      = ioctl_download || !w_empty || ((r_state != S_IDLE) && r_fgrant);
    assign dl_done      = r_dl_done;
    assign dl_overflow  = r_overflow;
    assign dl_range_err = r_range_err;

endmodule

// File: tb/tb_ioctl_sdram_arbiter.sv
// Scoreboard bench for ioctl_sdram_arbiter: expected SDRAM transactions and acks
// are queued by the stimulus and checked by a monitor as the DUT presents them.
module tb_ioctl_sdram_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [1:0]  req, we, ack;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rdata, sdram_din, sdram_dout;
    logic [15:0] sdram_addr;
    logic        sdram_rd, sdram_we, sdram_ready;
    logic        dl_busy, dl_done, dl_overflow, dl_range_err;

    ioctl_sdram_arbiter #(
        .ADDR_W(16), .CHANNELS(2), .FIFO_DEPTH(4), .DL_BASE(32'h8000), .DL_LIMIT(65535)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .req(req), .we(we), .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd),
        .sdram_we(sdram_we), .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
        .dl_busy(dl_busy), .dl_done(dl_done), .dl_overflow(dl_overflow),
        .dl_range_err(dl_range_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic w; logic [15:0] a; logic [7:0] d; } tx_t;
    typedef struct { logic [1:0] vec; logic [7:0] rd; } ack_t;

    tx_t  exp_tx[$];
    ack_t exp_ack[$];
    logic [7:0] mem [65536];
    int   n_tests = 0, n_fail = 0;
    int   lat = 2;
    int   n_dl_wr = 0, done_cnt = 0, done_at = -1, strobe_len = 0, last_strobe_len = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // SDRAM model: completes each strobe after lat cycles with a one-cycle ready.
    int sd_cnt = 0;
    initial begin
        sdram_ready = 1'b0;
        sdram_dout  = 8'h00;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                sd_cnt = 0;
                sdram_ready = 1'b0;
            end else if (sdram_ready) begin
                sdram_ready = 1'b0;
            end else if (sdram_rd || sdram_we) begin
                sd_cnt++;
                if (sd_cnt >= lat) begin
                    if (sdram_we) mem[sdram_addr] = sdram_din;
                    else          sdram_dout = mem[sdram_addr];
                    sdram_ready = 1'b1;
                    sd_cnt = 0;
                end
            end else begin
                sd_cnt = 0;
            end
        end
    end

    logic m_strobe, m_prev = 1'b0, m_cur_ok = 1'b0;
    tx_t  m_cur;
    ack_t m_ack;
    always @(negedge clk_sys) begin
        if (reset) begin
            m_prev   = 1'b0;
            m_cur_ok = 1'b0;
        end else begin
            m_strobe = sdram_rd | sdram_we;
            if (m_strobe && !m_prev) begin
                check("strobe_onehot", {sdram_rd, sdram_we} == 2'b11, 0);
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    m_cur_ok = 1'b0;
                    $display("FAIL tx_unexpected: got we=%0d addr=0x%0h din=0x%0h expected none",
                             sdram_we, sdram_addr, sdram_din);
                end else begin
                    m_cur = exp_tx.pop_front();
                    m_cur_ok = 1'b1;
                    check("tx_dir", sdram_we, m_cur.w);
                    check("tx_addr", sdram_addr, m_cur.a);
                    if (m_cur.w) check("tx_wdata", sdram_din, m_cur.d);
                end
                if (sdram_we && sdram_addr[15]) n_dl_wr++;
                strobe_len = 0;
            end else if (m_strobe && m_cur_ok) begin
                check("tx_hold", {sdram_we, sdram_rd, sdram_addr},
                      {m_cur.w, !m_cur.w, m_cur.a});
                if (m_cur.w) check("tx_hold_din", sdram_din, m_cur.d);
            end
            if (m_strobe) strobe_len++;
            else if (m_prev) last_strobe_len = strobe_len;
            if (ack != 2'b00) begin
                check("ack_strobe_low", m_strobe, 0);
                if (exp_ack.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_unexpected: got ack=%b expected none", ack);
                end else begin
                    m_ack = exp_ack.pop_front();
                    check("ack_vec", ack, m_ack.vec);
                    check("ack_rdata", rdata, m_ack.rd);
                end
            end
            if (dl_done) begin
                done_cnt++;
                done_at = n_dl_wr;
            end
            m_prev = m_strobe;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_ack(input int ch);
        bit got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk_sys);
            if (ack[ch]) got = 1'b1;
        end
        check($sformatf("ack_seen_ch%0d", ch), got, 1);
        req[ch] = 1'b0;
    endtask

    task automatic core_xfer(input int ch, input logic w, input logic [15:0] a, input logic [7:0] d);
        we[ch] = w;
        addr[ch*16 +: 16] = a;
        wdata[ch*8 +: 8] = d;
        req[ch] = 1'b1;
        wait_ack(ch);
        we[ch] = 1'b0;
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk_sys);
            if (!dl_busy && !sdram_rd && !sdram_we && exp_tx.size() == 0 && exp_ack.size() == 0)
                ok = 1'b1;
        end
        check("drain", ok, 1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500us");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        we = '0;
        wdata = '0;
        mem[16'h0010] = 8'h3C;
        mem[16'h0020] = 8'hC3;
        mem[16'h0040] = 8'h77;
        mem[16'h1234] = 8'hA5;

        // Reset with both channels requesting, then round-robin including an immediate re-request
        req = 2'b11;
        addr = {16'h0020, 16'h0010};
        tick(3);
        check("reset_outputs",
              {ack, rdata, sdram_addr, sdram_din, sdram_rd, sdram_we, dl_busy, dl_done, dl_overflow, dl_range_err}, 0);
        exp_tx.push_back('{1'b0, 16'h0010, 8'h00});
        exp_tx.push_back('{1'b0, 16'h0020, 8'h00});
        exp_tx.push_back('{1'b0, 16'h0040, 8'h00});
        exp_ack.push_back('{2'b01, 8'h3C});
        exp_ack.push_back('{2'b10, 8'hC3});
        exp_ack.push_back('{2'b01, 8'h77});
        reset = 1'b0;
        check("post_reset_no_strobe", sdram_rd | sdram_we, 0);
        fork
            begin
                wait_ack(0);
                addr[15:0] = 16'h0040;
                req[0] = 1'b1;
                wait_ack(0);
            end
            wait_ack(1);
        join
        tick(2);

        // Channel 1 read with 4-cycle SDRAM latency
        lat = 4;
        exp_tx.push_back('{1'b0, 16'h1234, 8'h00});
        exp_ack.push_back('{2'b10, 8'hA5});
        core_xfer(1, 1'b0, 16'h1234, 8'h00);
        tick(1);
        check("rd_strobe_len", last_strobe_len, 4);

        // Core write leaves rdata alone, read-back returns written byte
        lat = 2;
        exp_tx.push_back('{1'b1, 16'h0030, 8'h5A});
        exp_ack.push_back('{2'b01, 8'hA5});
        core_xfer(0, 1'b1, 16'h0030, 8'h5A);
        exp_tx.push_back('{1'b0, 16'h0030, 8'h00});
        exp_ack.push_back('{2'b01, 8'h5A});
        core_xfer(0, 1'b0, 16'h0030, 8'h00);
        tick(2);

        // Download of 4 bytes beats a continuously requesting channel 0
        n_dl_wr = 0;
        done_cnt = 0;
        exp_tx.push_back('{1'b1, 16'h8000, 8'h11});
        exp_tx.push_back('{1'b1, 16'h8001, 8'h22});
        exp_tx.push_back('{1'b1, 16'h8002, 8'h33});
        exp_tx.push_back('{1'b1, 16'h8003, 8'h44});
        exp_tx.push_back('{1'b0, 16'h0040, 8'h00});
        exp_ack.push_back('{2'b01, 8'h77});
        ioctl_download = 1'b1;
        tick(1);
        fork
            begin
                dl_byte(25'd0, 8'h11);
                dl_byte(25'd1, 8'h22);
                dl_byte(25'd2, 8'h33);
                dl_byte(25'd3, 8'h44);
                ioctl_download = 1'b0;
            end
            begin
                @(negedge clk_sys);
                core_xfer(0, 1'b0, 16'h0040, 8'h00);
            end
        join
        wait_idle();
        check("dl_done_count", done_cnt, 1);
        check("dl_done_after_4th", done_at, 4);

        // Six back-to-back bytes into a 4-deep FIFO with slow SDRAM
        lat = 10;
        done_cnt = 0;
        exp_tx.push_back('{1'b1, 16'h8010, 8'hA0});
        exp_tx.push_back('{1'b1, 16'h8011, 8'hA1});
        exp_tx.push_back('{1'b1, 16'h8012, 8'hA2});
        exp_tx.push_back('{1'b1, 16'h8013, 8'hA3});
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) dl_byte(25'(16 + i), 8'(8'hA0 + i));
        ioctl_download = 1'b0;
        wait_idle();
        check("overflow_set", {dl_overflow, dl_range_err}, 2'b10);
        ioctl_download = 1'b1;
        tick(2);
        check("overflow_cleared", dl_overflow, 0);
        ioctl_download = 1'b0;
        wait_idle();
        check("dl_done_per_download", done_cnt, 2);

        // Address window: 0x7FFF+0x8000 is the last legal byte, 0x8000 wraps past the limit
        lat = 2;
        exp_tx.push_back('{1'b1, 16'hFFFF, 8'h5E});
        ioctl_download = 1'b1;
        tick(1);
        dl_byte(25'h7FFF, 8'h5E);
        dl_byte(25'h8000, 8'hE5);
        ioctl_download = 1'b0;
        wait_idle();
        check("range_err_set", {dl_range_err, dl_overflow}, 2'b10);

        // Reset while a download write is on the bus
        lat = 20;
        exp_tx.push_back('{1'b1, 16'h8005, 8'h99});
        ioctl_download = 1'b1;
        tick(1);
        dl_byte(25'd5, 8'h99);
        ioctl_download = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk_sys);
            if (sdram_we) seen = 1'b1;
        end
        check("we_before_reset", seen, 1);
        tick(1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("reset_mid_tx", {sdram_we, sdram_rd, ack, dl_busy, dl_done, dl_range_err}, 0);
        reset = 1'b0;
        tick(25);
        check("no_reissue_after_reset", {sdram_we, sdram_rd, dl_busy}, 0);

        check("tx_queue_empty", exp_tx.size(), 0);
        check("ack_queue_empty", exp_ack.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
